// File: rtl/pong_pkg.sv
// pong_pkg
// Shared types and constants for the LED ping-pong game-play core.
//   state_e : ball controller FSM states
//   side_e  : which player lost the last point
//   SCORE_W : width of each score counter
package pong_pkg;

  localparam int SCORE_W = 4;

  typedef enum logic [2:0] {
    ST_SERVE_L   = 3'd0,
    ST_SERVE_R   = 3'd1,
    ST_MOVE_R    = 3'd2,
    ST_MOVE_L    = 3'd3,
    ST_POINT     = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_e;

  typedef enum logic {
    SIDE_L = 1'b0,
    SIDE_R = 1'b1
  } side_e;

endpackage

// File: rtl/btn_edge.sv
// btn_edge
// One-bit rising-edge detector. The input is registered once and a press is
// flagged in the cycle the input is high while its registered copy is low,
// so a held button produces exactly one press.
// Ports:
//   clk      : system clock
//   reset    : synchronous, active-high
//   btn_i    : conditioned button level
//   press_o  : single-cycle press indication (combinational from btn_i)
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  logic btn_q;

  always_ff @(posedge clk) begin
    if (reset) btn_q <= 1'b0;
    else       btn_q <= btn_i;
  end

  assign press_o = btn_i & ~btn_q;

endmodule

// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl
// Game-play core: moves a one-hot ball across an LED row on each game tick,
// evaluates paddle hits, keeps both scores and declares the winner.
// Ports:
//   clk        : system clock (same clock as the game-rate divider)
//   reset      : synchronous, active-high; clears all state
//   tick       : one-cycle ball-step pulse
//   btn_l      : left paddle level (synchronised, debounced)
//   btn_r      : right paddle level (synchronised, debounced)
//   led        : registered ball display, bit 0 is the left end
//   score_l    : registered left score
//   score_r    : registered right score
//   game_over  : registered, high while a winner is declared
// Build option:
//   PONG_EARLY_FAULT_EN : a paddle press before the ball reaches the end
//                         position loses the point like a miss.
//
// state        | meaning
// -------------+-----------------------------------------------
// ST_SERVE_L   | ball held at pos 0, waiting for left serve
// ST_SERVE_R   | ball held at pos N_LEDS-1, waiting for right serve
// ST_MOVE_R    | ball travelling toward the right end
// ST_MOVE_L    | ball travelling toward the left end
// ST_POINT     | point scored, all LEDs lit until next tick
// ST_GAME_OVER | winner's half lit until any press
module pong_ball_ctrl
  import pong_pkg::*;
#(
  parameter int N_LEDS    = 8,
  parameter int WIN_SCORE = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               btn_l,
  input  logic               btn_r,
  output logic [N_LEDS-1:0]  led,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over
);

  localparam int PW = $clog2(N_LEDS);
  localparam logic [PW-1:0]      POS_MAX   = PW'(N_LEDS - 1);
  localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
  localparam logic [N_LEDS-1:0]  LED_ONES  = '1;
  localparam logic [N_LEDS-1:0]  LED_ONE   = N_LEDS'(1);
  localparam logic [N_LEDS-1:0]  LEFT_MASK = LED_ONES >> (N_LEDS - N_LEDS / 2);

  logic press_l, press_r;
  logic early_l, early_r;

  state_e             state_q, state_d;
  side_e              loser_q, loser_d;
  logic [PW-1:0]      pos_q, pos_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic [N_LEDS-1:0]  led_q, led_d;
  logic               game_over_q, game_over_d;

  btn_edge u_edge_l (.clk(clk), .reset(reset), .btn_i(btn_l), .press_o(press_l));
  btn_edge u_edge_r (.clk(clk), .reset(reset), .btn_i(btn_r), .press_o(press_r));

`ifdef PONG_EARLY_FAULT_EN
  assign early_l = press_l;
  assign early_r = press_r;
`else
  assign early_l = 1'b0;
  assign early_r = 1'b0;
`endif

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s < WIN) ? s + SCORE_W'(1) : s;
  endfunction

  always_comb begin
    state_d   = state_q;
    loser_d   = loser_q;
    pos_d     = pos_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;

    unique case (state_q)
      ST_SERVE_L: begin
        pos_d = '0;
        if (press_l) state_d = ST_MOVE_R;
      end
      ST_SERVE_R: begin
        pos_d = POS_MAX;
        if (press_r) state_d = ST_MOVE_L;
      end
      ST_MOVE_R: begin
        // A hit at the end position takes priority over a same-cycle tick.
        if (press_r && pos_q == POS_MAX) begin
          state_d = ST_MOVE_L;
        end else if (early_r) begin
          state_d   = ST_POINT;
          loser_d   = SIDE_R;
          score_l_d = sat_inc(score_l_q);
        end else if (tick) begin
          if (pos_q == POS_MAX) begin
            state_d   = ST_POINT;
            loser_d   = SIDE_R;
            score_l_d = sat_inc(score_l_q);
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end
      end
      ST_MOVE_L: begin
        if (press_l && pos_q == '0) begin
          state_d = ST_MOVE_R;
        end else if (early_l) begin
          state_d   = ST_POINT;
          loser_d   = SIDE_L;
          score_r_d = sat_inc(score_r_q);
        end else if (tick) begin
          if (pos_q == '0) begin
            state_d   = ST_POINT;
            loser_d   = SIDE_L;
            score_r_d = sat_inc(score_r_q);
          end else begin
            pos_d = pos_q - PW'(1);
          end
        end
      end
      ST_POINT: begin
        if (tick) begin
          if (((loser_q == SIDE_R) ? score_l_q : score_r_q) == WIN) begin
            state_d = ST_GAME_OVER;
          end else if (loser_q == SIDE_L) begin
            state_d = ST_SERVE_L;
            pos_d   = '0;
          end else begin
            state_d = ST_SERVE_R;
            pos_d   = POS_MAX;
          end
        end
      end
      ST_GAME_OVER: begin
        if (press_l || press_r) begin
          state_d   = ST_SERVE_L;
          pos_d     = '0;
          score_l_d = '0;
          score_r_d = '0;
        end
      end
      default: begin
        state_d = ST_SERVE_L;
        pos_d   = '0;
      end
    endcase

    // Display is derived from the next state so it lands with the state.
    unique case (state_d)
      ST_POINT:     led_d = LED_ONES;
      ST_GAME_OVER: led_d = (loser_d == SIDE_R) ? LEFT_MASK : ~LEFT_MASK;
      default:      led_d = LED_ONE << pos_d;
    endcase
    game_over_d = (state_d == ST_GAME_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SERVE_L;
      loser_q     <= SIDE_L;
      pos_q       <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      led_q       <= LED_ONE;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      loser_q     <= loser_d;
      pos_q       <= pos_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      led_q       <= led_d;
      game_over_q <= game_over_d;
    end
  end

  assign led       = led_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
module tb_pong_ball_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       btn_l = 1'b0;
  logic       btn_r = 1'b0;
  logic [7:0] led;
  logic [3:0] score_l, score_r;
  logic       game_over;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_led;

  pong_ball_ctrl #(.N_LEDS(8), .WIN_SCORE(2)) dut (
    .clk(clk), .reset(reset), .tick(tick), .btn_l(btn_l), .btn_r(btn_r),
    .led(led), .score_l(score_l), .score_r(score_r), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1; cycle(); tick = 1'b0;
  endtask

  task automatic press_l();
    btn_l = 1'b1; cycle(); btn_l = 1'b0;
  endtask

  task automatic press_r();
    btn_r = 1'b1; cycle(); btn_r = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cycle(); cycle(); reset = 1'b0;
    n_checks++; if (led !== 8'h01) begin n_fail++; $display("FAIL reset_led: got %h want 01", led); end
    n_checks++; if (score_l !== 4'd0) begin n_fail++; $display("FAIL reset_score_l: got %0d want 0", score_l); end
    n_checks++; if (score_r !== 4'd0) begin n_fail++; $display("FAIL reset_score_r: got %0d want 0", score_r); end
    n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL reset_game_over: got %b want 0", game_over); end
  endtask

  task automatic test_serve_move();
    do_tick();
    n_checks++; if (led !== 8'h01) begin n_fail++; $display("FAIL serve_tick_ignored: got %h want 01", led); end
    press_l();
    n_checks++; if (led !== 8'h01) begin n_fail++; $display("FAIL serve_press_pos: got %h want 01", led); end
    for (int i = 1; i < 8; i++) begin
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      exp_led = 8'h01 << i;
      n_checks++; if (led !== exp_led) begin n_fail++; $display("FAIL move_r_step%0d: got %h want %h", i, led, exp_led); end
      cycle();
      n_checks++; if (led !== exp_led) begin n_fail++; $display("FAIL move_r_hold%0d: got %h want %h", i, led, exp_led); end
    end
  endtask

  // Ball at 0x80 in MOVE_R on entry; leaves it at 0x80 in MOVE_R again.
  task automatic test_hit_and_tick();
    btn_r = 1'b1; tick = 1'b1; cycle(); btn_r = 1'b0; tick = 1'b0;
    n_checks++; if (led !== 8'h80) begin n_fail++; $display("FAIL hit_tick_led: got %h want 80", led); end
    n_checks++; if (score_l !== 4'd0) begin n_fail++; $display("FAIL hit_tick_score: got %0d want 0", score_l); end
    do_tick();
    n_checks++; if (led !== 8'h40) begin n_fail++; $display("FAIL hit_reverse: got %h want 40", led); end
    for (int i = 0; i < 6; i++) do_tick();
    n_checks++; if (led !== 8'h01) begin n_fail++; $display("FAIL move_l_end: got %h want 01", led); end
    press_l();
    n_checks++; if (led !== 8'h01) begin n_fail++; $display("FAIL hit_l_led: got %h want 01", led); end
    for (int i = 0; i < 7; i++) do_tick();
    n_checks++; if (led !== 8'h80) begin n_fail++; $display("FAIL rerally_end: got %h want 80", led); end
  endtask

  task automatic test_miss_and_game_over();
    do_tick();
    n_checks++; if (score_l !== 4'd1) begin n_fail++; $display("FAIL miss1_score_l: got %0d want 1", score_l); end
    n_checks++; if (led !== 8'hFF) begin n_fail++; $display("FAIL miss1_point_led: got %h want ff", led); end
    do_tick();
    n_checks++; if (led !== 8'h80) begin n_fail++; $display("FAIL serve_r_led: got %h want 80", led); end
    do_tick();
    n_checks++; if (led !== 8'h80) begin n_fail++; $display("FAIL serve_r_tick_ignored: got %h want 80", led); end
    press_r();
    for (int i = 0; i < 7; i++) do_tick();
    n_checks++; if (led !== 8'h01) begin n_fail++; $display("FAIL serve_r_rally: got %h want 01", led); end
    press_l();
    for (int i = 0; i < 7; i++) do_tick();
    do_tick();
    n_checks++; if (score_l !== 4'd2) begin n_fail++; $display("FAIL miss2_score_l: got %0d want 2", score_l); end
    n_checks++; if (score_r !== 4'd0) begin n_fail++; $display("FAIL miss2_score_r: got %0d want 0", score_r); end
    n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL point_no_game_over: got %b want 0", game_over); end
    do_tick();
    n_checks++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL game_over_flag: got %b want 1", game_over); end
    n_checks++; if (led !== 8'h0F) begin n_fail++; $display("FAIL game_over_led: got %h want 0f", led); end
    do_tick();
    n_checks++; if (score_l !== 4'd2) begin n_fail++; $display("FAIL score_saturate: got %0d want 2", score_l); end
    press_r();
    n_checks++; if (led !== 8'h01) begin n_fail++; $display("FAIL restart_led: got %h want 01", led); end
    n_checks++; if (score_l !== 4'd0 || score_r !== 4'd0) begin n_fail++; $display("FAIL restart_scores: got %0d/%0d want 0/0", score_l, score_r); end
    n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL restart_game_over: got %b want 0", game_over); end
  endtask

  task automatic test_early_press();
    press_l();
    for (int i = 0; i < 3; i++) do_tick();
    n_checks++; if (led !== 8'h08) begin n_fail++; $display("FAIL early_setup: got %h want 08", led); end
    press_r();
`ifdef PONG_EARLY_FAULT_EN
    n_checks++; if (score_l !== 4'd1) begin n_fail++; $display("FAIL early_score: got %0d want 1", score_l); end
    n_checks++; if (led !== 8'hFF) begin n_fail++; $display("FAIL early_point: got %h want ff", led); end
`else
    n_checks++; if (score_l !== 4'd0) begin n_fail++; $display("FAIL early_score: got %0d want 0", score_l); end
    n_checks++; if (led !== 8'h08) begin n_fail++; $display("FAIL early_ignored: got %h want 08", led); end
    do_tick();
    n_checks++; if (led !== 8'h10) begin n_fail++; $display("FAIL early_continue: got %h want 10", led); end
`endif
  endtask

  task automatic test_both_and_reset();
    reset = 1'b1; cycle(); reset = 1'b0;
    btn_l = 1'b1; btn_r = 1'b1; cycle(); btn_l = 1'b0; btn_r = 1'b0;
    do_tick();
    n_checks++; if (led !== 8'h02) begin n_fail++; $display("FAIL both_btn_serve: got %h want 02", led); end
    do_tick(); do_tick();
    n_checks++; if (led !== 8'h08) begin n_fail++; $display("FAIL mid_rally_setup: got %h want 08", led); end
    reset = 1'b1; tick = 1'b1; btn_r = 1'b1; cycle(); reset = 1'b0; tick = 1'b0; btn_r = 1'b0;
    n_checks++; if (led !== 8'h01) begin n_fail++; $display("FAIL mid_reset_led: got %h want 01", led); end
    n_checks++; if (score_l !== 4'd0 || score_r !== 4'd0) begin n_fail++; $display("FAIL mid_reset_scores: got %0d/%0d want 0/0", score_l, score_r); end
    n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL mid_reset_game_over: got %b want 0", game_over); end
    do_tick();
    n_checks++; if (led !== 8'h01) begin n_fail++; $display("FAIL mid_reset_serve: got %h want 01", led); end
  endtask

  initial begin
    test_reset();
    test_serve_move();
    test_hit_and_tick();
    test_miss_and_game_over();
    test_early_press();
    test_both_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
